// File: rtl/ifu_fetch_unit.sv
// PC register and instruction-fetch sequencer: one IM word read per instruction over a
// variable-latency req/ack port, handed to decode over valid/ready, with sticky PC fault.
module ifu_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        START = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Exclusive upper bound of the fetch window, kept in 33 bits so it cannot wrap.
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    state_t      state;
    state_t      state_next;
    logic        armed;
    logic [31:0] pc;

    function automatic logic is_legal(input logic [31:0] addr);
        logic [32:0] wide;
        wide = {1'b0, addr};
        return (addr[1:0] == 2'b00) && (wide >= {1'b0, IM_BASE}) && (wide < IM_LIMIT);
    endfunction

    always_comb begin
        // NOTE: next state defaults to the current one before the case, so every path
        // assigns it and no latch is inferred.
        state_next = state;
        case (state)
            START: if (armed)       state_next = is_legal(pc) ? REQ : FAULT;
            REQ:   if (imem_ack)    state_next = HOLD;
            HOLD:  if (instr_ready) state_next = is_legal(next_pc) ? REQ : FAULT;
            FAULT:                  state_next = FAULT;
            default:                state_next = START;
        endcase
    end

    // START lasts one full cycle after release; armed marks that the first edge has passed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= START;
            armed <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
            state <= state_next;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            fetch_count <= '0;
        end else begin
            if (state == REQ && imem_ack) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (state == HOLD && instr_ready) begin
                pc          <= next_pc;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    // Handshake outputs are pure decodes of the state register: mutually exclusive, no input path.
    assign imem_req    = (state == REQ);
    assign instr_valid = (state == HOLD);
    assign fault       = (state == FAULT);
    assign imem_addr   = pc;

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Directed self-checking bench for ifu_fetch_unit: reset, fetch latency, decode
// back-pressure, misaligned/out-of-range faults, reset during a request, and the last legal word.
module tb_ifu_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    ifu_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .next_pc     (next_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset for three cycles and release; the first request follows two edges later.
    task automatic do_reset();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        step();
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        check({tag, "_req"}, imem_req, 1);
        check({tag, "_addr"}, imem_addr, exp_addr);
    endtask

    task automatic serve(input string tag, input logic [31:0] data, input logic [31:0] exp_pc);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        check({tag, "_valid"}, instr_valid, 1);
        check({tag, "_instr"}, instr, data);
        check({tag, "_ipc"}, instr_pc, exp_pc);
    endtask

    task automatic consume(input logic [31:0] npc);
        instr_ready = 1'b1;
        next_pc     = npc;
        step();
        instr_ready = 1'b0;
        next_pc     = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        next_pc     = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;

        // 1: outputs idle during reset, request on the 2nd edge after release
        repeat (3) step();
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_ipc", instr_pc, 0);
        check("rst_fault", fault, 0);
        check("rst_count", fetch_count, 0);
        reset = 1'b1;
        step();
        check("edge1_req", imem_req, 0);
        step();
        check("edge2_req", imem_req, 1);
        check("edge2_addr", imem_addr, 32'h0000_3000);

        // 2: slow ack, address held while waiting
        for (int i = 0; i < 2; i++) begin
            step();
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, 32'h0000_3000);
            check("wait_valid", instr_valid, 0);
        end
        serve("fetch0", 32'h3C01_1234, 32'h0000_3000);
        check("fetch0_noreq", imem_req, 0);

        // 3: decode back-pressure, then consume to 0x3004
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1;
            imem_rdata = 32'hFFFF_FFFF;
            step();
            check("bp_valid", instr_valid, 1);
            check("bp_instr", instr, 32'h3C01_1234);
            check("bp_ipc", instr_pc, 32'h0000_3000);
            check("bp_noreq", imem_req, 0);
        end
        imem_ack = 1'b0;
        consume(32'h0000_3004);
        check("c1_req", imem_req, 1);
        check("c1_addr", imem_addr, 32'h0000_3004);
        check("c1_count", fetch_count, 1);
        check("c1_valid", instr_valid, 0);

        // 4a: misaligned next_pc faults and freezes pc
        serve("fetch1", 32'hAAAA_0001, 32'h0000_3004);
        consume(32'h0000_3002);
        check("mis_fault", fault, 1);
        check("mis_req", imem_req, 0);
        check("mis_valid", instr_valid, 0);
        check("mis_pc", imem_addr, 32'h0000_3002);
        check("mis_count", fetch_count, 2);
        imem_ack = 1'b1;
        instr_ready = 1'b1;
        next_pc = 32'h0000_3000;
        repeat (3) step();
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        check("mis_sticky", fault, 1);
        check("mis_pc_held", imem_addr, 32'h0000_3002);
        check("mis_count_held", fetch_count, 2);

        // 4b: one past the end of IM faults
        do_reset();
        check("rst2_fault", fault, 0);
        wait_req("r2", 32'h0000_3000);
        serve("fetch2", 32'h1111_2222, 32'h0000_3000);
        consume(32'h0000_7000);
        check("oor_fault", fault, 1);
        check("oor_req", imem_req, 0);
        check("oor_pc", imem_addr, 32'h0000_7000);
        check("oor_count", fetch_count, 1);

        // 5: reset during an outstanding request, ack arriving while in reset
        do_reset();
        wait_req("r3", 32'h0000_3000);
        serve("fetch3", 32'h5555_6666, 32'h0000_3000);
        consume(32'h0000_3008);
        wait_req("r3b", 32'h0000_3008);
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("midrst_pc", imem_addr, 32'h0000_3000);
        check("midrst_req", imem_req, 0);
        step();
        check("midrst_valid", instr_valid, 0);
        check("midrst_instr", instr, 0);
        check("midrst_ipc", instr_pc, 0);
        check("midrst_count", fetch_count, 0);
        imem_ack = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
        check("rel_req", imem_req, 1);
        check("rel_addr", imem_addr, 32'h0000_3000);
        check("rel_instr", instr, 0);

        // 6: last legal word fetches normally, next word faults
        serve("fetch4", 32'h0BAD_F00D, 32'h0000_3000);
        consume(32'h0000_6FFC);
        check("last_req", imem_req, 1);
        check("last_addr", imem_addr, 32'h0000_6FFC);
        check("last_fault", fault, 0);
        serve("fetch5", 32'h1234_5678, 32'h0000_6FFC);
        consume(32'h0000_7000);
        check("end_fault", fault, 1);
        check("end_pc", imem_addr, 32'h0000_7000);
        check("end_count", fetch_count, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
